neuron_seq_ctrl: RTL

Sequencing controller for one neuron of the simpleNeuron datapath. It accepts a start command with a bias, then streams N_INPUTS signed input/weight pairs over a valid/ready handshake. It accumulates bias + Σ(x·w) with saturation, hands the 17-bit sum to the external ReLU activation unit (one-cycle registered stage), and captures the result. It presents that result on a valid/ready output port.

---
 rtl/neuron_seq_ctrl.sv | 96 +++++++++
 1 files changed

// File: rtl/neuron_seq_ctrl.sv
// Sequencing controller for one simpleNeuron: accumulates bias + sum(x*w) with
// 17-bit saturation, runs it through the external registered ReLU, presents y.
module neuron_seq_ctrl #(
    parameter int N_INPUTS = 4,
    parameter int DW       = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic signed [15:0]   bias,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] x,
    input  logic signed [DW-1:0] w,
    output logic signed [16:0]   act_in,
    input  logic signed [16:0]   act_out,
    output logic                 busy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [16:0]   y
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ACCUM = 3'd1;
    localparam logic [2:0] S_ACT   = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_OUT   = 3'd4;

    localparam logic [7:0]         LAST_BEAT = 8'(N_INPUTS - 1);
    localparam logic signed [16:0] SAT_MAX   = 17'sh0FFFF;
    localparam logic signed [16:0] SAT_MIN   = 17'sh10000;

    logic [2:0]             state_q, state_d;
    logic signed [16:0]     acc_q, acc_d;
    logic [7:0]             cnt_q, cnt_d;
    logic signed [16:0]     y_q, y_d;
    logic signed [2*DW-1:0] prod;
    logic signed [17:0]     sum;
    logic signed [16:0]     sum_sat;

    assign prod = (2*DW)'(x) * (2*DW)'(w);
    assign sum  = 18'(acc_q) + 18'(prod);
    // The 18-bit sum fits in 17 bits exactly when its top two bits agree.
    assign sum_sat = (sum[17] != sum[16]) ? (sum[17] ? SAT_MIN : SAT_MAX) : sum[16:0];

    always_comb begin
        // NOTE: every next-state variable defaults to its current value first, so no path infers a latch.
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d   = 17'(bias);
                    cnt_d   = '0;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (in_valid) begin
                    acc_d = sum_sat;
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == LAST_BEAT) state_d = S_ACT;
                end
            end
            S_ACT:   state_d = S_WAIT;
            S_WAIT: begin
                y_d     = act_out;
                state_d = S_OUT;
            end
            S_OUT:   if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state updates use non-blocking assignments; reset is sampled on the clock edge only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
        end
    end

    assign in_ready  = (state_q == S_ACCUM);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_OUT);
    assign act_in    = acc_q;
    assign y         = y_q;
endmodule
